// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port controller and the arbiter above it.
//   mem_req_t   : one tagged request as it travels between blocks
//   mem_state_e : controller FSM states
//   RW_READ/RW_WRITE : encoding of the request direction bit
package mem_pkg;

  localparam int MEM_CORE_W = 2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef struct packed {
    logic [63:0]           addr;
    logic [63:0]           wdata;
    logic                  write;
    logic [MEM_CORE_W-1:0] core;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

endpackage

// File: rtl/mem_port_ctrl_fifo.sv
// Small synchronous FIFO with asynchronous (combinational) head read so the
// consumer can act on the head entry in the same cycle it pops it.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   push, din          : write din when push and not full
//   pop, dout          : dout is the current head; pop advances it when not empty
//   full, empty, count : occupancy, all derived from the registered count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: queues tagged requests from the arbiter and plays
// them one at a time onto a req/ack memory port, returning tagged read data
// (or a timeout error) in order.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready + req_*       : upstream request handshake and payload
//   resp_valid/resp_ready + resp_*    : read response handshake, data, tag, error
//   mem_req/mem_ack + mem_*           : external memory port (strobe held until ack)
//   busy                              : queued work or a transaction in progress
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int CORE_W  = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  input  logic              req_write,
  input  logic [CORE_W-1:0] req_core,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic [CORE_W-1:0] resp_core,
  output logic              resp_err,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_rw,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  if (CORE_W != $clog2(NCORES)) begin : g_core_w_check
    $error("mem_port_ctrl: CORE_W must equal clog2(NCORES)");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("mem_port_ctrl: DEPTH must be a power of two, at least 2");
  end

  localparam int ENTRY_W = 64 + 64 + 1 + CORE_W;
  localparam int AW      = $clog2(DEPTH);
  // Counter holds the number of WAIT cycles already completed, so the
  // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               fifo_push;
  logic               fifo_pop;

  logic [63:0]        head_addr;
  logic [63:0]        head_wdata;
  logic               head_write;
  logic [CORE_W-1:0]  head_core;

  mem_state_e         state_q;
  logic [7:0]         tmo_cnt_q;
  logic [CORE_W-1:0]  tag_q;
  logic               mem_req_q;
  logic [63:0]        mem_addr_q;
  logic [63:0]        mem_wdata_q;
  logic               mem_rw_q;
  logic               resp_valid_q;
  logic [63:0]        resp_data_q;
  logic [CORE_W-1:0]  resp_core_q;
  logic               resp_err_q;

  // Ready comes from the registered occupancy only; held low while in reset.
  assign req_ready  = ~reset & ~fifo_full;
  assign fifo_push  = req_valid & req_ready;
  assign fifo_pop   = (state_q == IDLE) & ~fifo_empty;
  assign push_entry = {req_addr, req_wdata, req_write, req_core};

  assign head_addr  = head_entry[ENTRY_W-1 -: 64];
  assign head_wdata = head_entry[CORE_W+64 -: 64];
  assign head_write = head_entry[CORE_W];
  assign head_core  = head_entry[CORE_W-1:0];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      tag_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rw_q     <= RW_READ;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_core_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // The head is popped this cycle and presented on the port at the edge.
          if (!fifo_empty) begin
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_wdata;
            mem_rw_q    <= head_write;
            tag_q       <= head_core;
            mem_req_q   <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (mem_rw_q == RW_READ) begin
              resp_data_q  <= mem_rdata;
              resp_core_q  <= tag_q;
              resp_err_q   <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            mem_req_q <= 1'b0;
            if (mem_rw_q == RW_READ) begin
              resp_data_q  <= '0;
              resp_core_q  <= tag_q;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_core  = resp_core_q;
  assign resp_err   = resp_err_q;
  assign busy       = (fifo_count != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: accepted requests are queued in issue
// order, a memory responder checks each issue and produces the expected
// response, and a response monitor pops and compares on each handshake.
module tb_mem_port_ctrl;

  localparam int CW  = 2;
  localparam int TMO = 255;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_addr;
  logic [63:0]   req_wdata;
  logic          req_write;
  logic [CW-1:0] req_core;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_data;
  logic [CW-1:0] resp_core;
  logic          resp_err;
  logic          mem_req;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_rw;
  logic          mem_ack;
  logic [63:0]   mem_rdata;
  logic          busy;

  always #5 clock = ~clock;

  mem_port_ctrl #(
    .NCORES  (4),
    .CORE_W  (CW),
    .DEPTH   (4),
    .TIMEOUT (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_write  (req_write),
    .req_core   (req_core),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_core  (resp_core),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  typedef struct {
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic          write;
    logic [CW-1:0] core;
  } req_t;

  typedef struct {
    logic [63:0]   data;
    logic [CW-1:0] core;
    logic          err;
  } rsp_t;

  req_t        issue_q[$];
  rsp_t        exp_q[$];
  int          plan_q[$];   // per issue: ack on this WAIT cycle, 0 = never ack
  logic [63:0] rdata_q[$];

  int checks = 0;
  int errors = 0;

  // responder / monitor state
  bit   active = 0;
  bit   chk_low = 0;
  bit   stray_ack = 0;
  bit   last_acc = 0;
  bit   hold_prev = 0;
  int   w = 0;
  int   plan = 0;
  req_t cur;
  logic [63:0]   hold_data;
  logic [CW-1:0] hold_core;
  logic          hold_err;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request acceptance -> expected issue order
  always @(negedge clock) begin
    last_acc = 1'b0;
    if (!reset && req_valid && req_ready) begin
      req_t r;
      r.addr  = req_addr;
      r.wdata = req_wdata;
      r.write = req_write;
      r.core  = req_core;
      issue_q.push_back(r);
      last_acc = 1'b1;
    end
  end

  // Memory responder: checks each issue, acks per plan, predicts responses
  always @(negedge clock) begin
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (stray_ack) begin
      mem_ack = 1'b1;
    end else if (chk_low) begin
      chk_low = 1'b0;
      check(!mem_req, "mem_req_drop", 64'(mem_req), 64'd0);
    end else if (mem_req) begin
      if (!active) begin
        if (issue_q.size() == 0) begin
          check(1'b0, "spurious_issue", mem_addr, 64'd0);
        end else begin
          cur    = issue_q.pop_front();
          active = 1'b1;
          w      = 0;
          plan   = (plan_q.size() != 0) ? plan_q.pop_front() : int'($urandom_range(1, 8));
          check(mem_addr == cur.addr, "issue_addr", mem_addr, cur.addr);
          check(mem_rw == cur.write, "issue_rw", 64'(mem_rw), 64'(cur.write));
          if (cur.write) check(mem_wdata == cur.wdata, "issue_wdata", mem_wdata, cur.wdata);
          $display("issue addr=%h rw=%0b core=%0d plan=%0d", cur.addr, cur.write, cur.core, plan);
        end
      end else begin
        check(mem_addr == cur.addr && mem_rw == cur.write, "issue_stable", mem_addr, cur.addr);
      end
      if (active) begin
        w++;
        if (plan != 0 && w == plan) begin
          rsp_t e;
          mem_ack = 1'b1;
          if (rdata_q.size() != 0) mem_rdata = rdata_q.pop_front();
          if (!cur.write) begin
            e.data = mem_rdata; e.core = cur.core; e.err = 1'b0;
            exp_q.push_back(e);
          end
          active  = 1'b0;
          chk_low = 1'b1;
        end else if (w == TMO) begin
          rsp_t e;
          if (!cur.write) begin
            e.data = 64'd0; e.core = cur.core; e.err = 1'b1;
            exp_q.push_back(e);
          end
          active  = 1'b0;
          chk_low = 1'b1;
        end
      end
    end else if (active) begin
      check(1'b0, "mem_req_early_drop", 64'(w), 64'(plan));
      active = 1'b0;
    end
  end

  // Response monitor: hold stability and in-order scoreboard compare
  always @(negedge clock) begin
    if (resp_valid) begin
      if (hold_prev) begin
        check(resp_data == hold_data && resp_core == hold_core && resp_err == hold_err,
              "resp_hold", resp_data, hold_data);
      end
      if (resp_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_resp", resp_data, 64'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check(resp_data == e.data, "resp_data", resp_data, e.data);
          check(resp_core == e.core, "resp_core", 64'(resp_core), 64'(e.core));
          check(resp_err == e.err, "resp_err", 64'(resp_err), 64'(e.err));
          $display("resp core=%0d data=%h err=%0b", resp_core, resp_data, resp_err);
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        hold_data = resp_data;
        hold_core = resp_core;
        hold_err  = resp_err;
      end
    end else begin
      if (hold_prev) check(1'b0, "resp_dropped", 64'd0, 64'd1);
      hold_prev = 1'b0;
    end
  end

  task automatic rand_fields();
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_write = 1'($urandom_range(0, 1));
    req_core  = CW'($urandom_range(0, 3));
  endtask

  task automatic push_req(input logic [63:0] a, input logic [63:0] d,
                          input logic wr, input logic [CW-1:0] c);
    int n = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = wr; req_core = c;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 600);
    if (n >= 600) check(1'b0, "push_timeout", 64'(n), 64'd600);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((issue_q.size() != 0 || exp_q.size() != 0 || busy || active) && n < limit);
    check(n < limit, name, 64'(n), 64'(limit));
  endtask

  task automatic flush_model();
    issue_q.delete();
    exp_q.delete();
    plan_q.delete();
    rdata_q.delete();
    active    = 1'b0;
    chk_low   = 1'b0;
    hold_prev = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_write = 1'b0; req_core = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check(!req_ready, "ready_in_reset", 64'(req_ready), 64'd0);
    check(!mem_req, "reset_mem_req", 64'(mem_req), 64'd0);
    check(!resp_valid, "reset_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check(req_ready, "ready_after_reset", 64'(req_ready), 64'd1);
    check(!busy, "busy_after_reset", 64'(busy), 64'd0);
    check(mem_addr == 64'd0 && mem_wdata == 64'd0 && !mem_rw, "reset_mem_bus", mem_addr, 64'd0);
    check(resp_data == 64'd0 && resp_core == '0 && !resp_err, "reset_resp_bus", resp_data, 64'd0);

    // Single read, ack on 3rd WAIT cycle, response back-pressured 5 cycles
    plan_q.push_back(3);
    rdata_q.push_back(64'hDEAD_BEEF);
    push_req(64'h1000, 64'h0, 1'b0, 2'd2);
    @(negedge clock);
    check(!mem_req, "issue_latency_early", 64'(mem_req), 64'd0);
    @(negedge clock);
    check(mem_req, "issue_latency", 64'(mem_req), 64'd1);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clock); n++; end
    check(resp_valid, "read_resp_seen", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check(resp_valid, "resp_held_valid", 64'(resp_valid), 64'd1);
    end
    @(posedge clock); #1 resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check(!resp_valid, "resp_clear", 64'(resp_valid), 64'd0);
    drain(50, "drain_read");

    // Write, ack on first WAIT cycle, no response
    plan_q.push_back(1);
    push_req(64'h2000, 64'h55, 1'b1, 2'd1);
    repeat (6) @(negedge clock);
    check(!busy, "write_idle", 64'(busy), 64'd0);
    drain(50, "drain_write");

    // FIFO full behind a long in-flight transaction
    plan_q.push_back(40);
    push_req(64'hA000, 64'h0, 1'b0, 2'd3);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      rand_fields();
      @(negedge clock);
      check(req_ready == (i < 4), "full_ready", 64'(req_ready), 64'(i < 4));
      if (i < 4) begin @(posedge clock); #1; end
    end
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clock); n++; end
    check(req_ready, "ready_return", 64'(req_ready), 64'd1);
    @(posedge clock); #1 req_valid = 1'b0;
    drain(300, "drain_full");

    // Timeout on a read, then a normal read; write timeout too
    plan_q.push_back(0);
    plan_q.push_back(2);
    plan_q.push_back(0);
    push_req(64'hB000, 64'h0, 1'b0, 2'd3);
    push_req(64'hB008, 64'h0, 1'b0, 2'd0);
    push_req(64'hB010, 64'h77, 1'b1, 2'd1);
    drain(800, "drain_timeout");

    // Ack on the very last allowed WAIT cycle
    plan_q.push_back(TMO);
    push_req(64'hC000, 64'h0, 1'b0, 2'd1);
    drain(400, "drain_collision");

    // Reset with one in flight and three queued
    repeat (4) plan_q.push_back(0);
    for (int i = 0; i < 4; i++) push_req({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, CW'(i));
    repeat (3) @(negedge clock);
    check(busy && mem_req, "busy_before_reset", 64'(busy), 64'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check(!req_ready, "ready_in_reset_pulse", 64'(req_ready), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    flush_model();
    @(negedge clock);
    check(!mem_req && !mem_rw && mem_addr == 64'd0 && mem_wdata == 64'd0,
          "mid_reset_mem", mem_addr, 64'd0);
    check(!resp_valid && resp_data == 64'd0 && resp_core == '0 && !resp_err,
          "mid_reset_resp", resp_data, 64'd0);
    check(!busy && req_ready, "mid_reset_fifo_empty", 64'(busy), 64'd0);
    @(posedge clock); #1 stray_ack = 1'b1;
    @(posedge clock); #1 stray_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check(!resp_valid && !busy && !mem_req, "stray_ack_ignored", 64'(resp_valid), 64'd0);
    end

    // Randomised traffic with random back-pressure
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clock); #1;
      resp_ready = 1'($urandom_range(0, 1));
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 2) != 0);
        rand_fields();
      end
    end
    @(posedge clock); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    drain(2000, "drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
